sbox_lane_pipe: RTL and testbench
=================================

Name: sbox_lane_pipe

Overview:
- Parametrised, pipelined AES byte-substitution unit for the AES datapath.
- Applies the forward S-box (SubBytes) or inverse S-box (InvSubBytes) to NUM_LANES bytes in parallel; mode is selected per transaction.
- Sits between the round-control FSM and ShiftRows/MixColumns.
- Also serves the key expansion path (SubWord) with NUM_LANES=4.
- Uses a valid/ready handshake with full backpressure, so encrypt and decrypt cores can share it.

Parameters:
- NUM_LANES, 4, number of byte lanes processed per beat (legal: 1..16).
- PIPE_STAGES, 1, register stages between input and output (legal: 1 or 2).
- TAG_W, 4, width of the opaque sideband tag carried alongside data (legal: >=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box.
- in_data  input  8*NUM_LANES  lane i = in_data[8i+7:8i].
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  8*NUM_LANES  substituted bytes, same lane mapping as in_data.
- out_tag  output  TAG_W  tag of the beat on out_data.
- out_inv  output  1  mode the beat was processed with.
- busy  output  1  at least one stage holds a valid beat.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high at a clk edge clears state.
- Reset values:
  - out_valid=0, busy=0.
  - out_data=0, out_tag=0, out_inv=0.
  - All internal stage valids = 0.
  - in_ready=1 in the cycle after reset deasserts.
- Tables:
  - Forward: the 256-entry FIPS-197 S-box.
  - Inverse: the 256-entry FIPS-197 inverse S-box.
  - Every 8-bit input is mapped; there is no default/undefined output.
  - Each lane has its own forward and inverse lookup. in_inv selects the lookup for all lanes of the beat.
- Handshake:
  - A beat transfers in when in_valid && in_ready at a clk edge.
  - A beat transfers out when out_valid && out_ready.
  - in_data, in_tag and in_inv are sampled only on input transfer.
  - While out_valid=1 && out_ready=0, out_data, out_tag and out_inv hold stable and out_valid stays 1.
- Pipeline: elastic register chain, stage k holds {valid, data, tag, inv}.
  - Last stage advances when it is empty or out_ready=1.
  - Stage k advances when stage k+1 is empty or advancing.
  - in_ready = stage 1 empty or stage 1 advancing. This is combinational from out_ready; the chain has no bubbles.
- Lookup placement:
  - PIPE_STAGES=1: lookup is combinational on the input side; stage 1 registers the substituted bytes.
  - PIPE_STAGES=2: stage 1 registers the raw inputs, the lookup is applied between stage 1 and stage 2, and stage 2 registers the result.
- Latency and throughput:
  - Latency from input transfer to out_valid is PIPE_STAGES cycles when not stalled.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
  - Capacity is PIPE_STAGES beats.
  - Order is preserved; mode may change on every beat without flush or bubble.
- Full: with all stages valid and out_ready=0, in_ready=0. An in_valid beat is not accepted and the source must hold it.
- Simultaneous events:
  - In the same cycle, an output transfer and an input transfer when full are both legal.
  - The occupancy is then unchanged.
- Empty: out_valid=0; out_data holds its last value and is don't-care.
- busy = OR of all stage valids.
- Reset mid-operation: all in-flight beats are discarded and none appear at the output after reset.

Test Plan:
- Lane mapping, NUM_LANES=4, PIPE_STAGES=1, out_ready=1, in_inv=0, in_data=32'h00010253 -> out_data=32'h637C77ED one cycle later, out_tag equals in_tag.
- Inverse mode, same config, in_inv=1, in_data=32'h637C77ED -> out_data=32'h00010253, out_inv=1.
- Exhaustive sweep, NUM_LANES=16, lane i driven with byte (b+i) mod 256 for b=0..255, mode alternating every beat -> every lane matches the FIPS-197 tables. Beats arrive back-to-back with no bubble, and inv(fwd(x))==x for all x.
- Backpressure, PIPE_STAGES=2:
  - Hold out_ready=0 and offer 3 beats with tags 1, 2, 3 -> beats 1 and 2 accepted, then in_ready=0; beat 3 is held with out_data stable.
  - Release out_ready -> tags 1, 2, 3 emerge in order, with no loss or duplication.
- Full with simultaneous transfers, PIPE_STAGES=2: unit full, out_ready=1 and in_valid=1 in the same cycle -> one beat out and one beat in, busy stays 1.
- Reset mid-operation: 2 beats in flight, assert rst for one cycle -> next cycle out_valid=0, busy=0, in_ready=1, and no stale beat is ever emitted.

Source files
------------

// File: rtl/sbox_lane_pipe.sv
// AES SubBytes / InvSubBytes over NUM_LANES byte lanes, elastic register chain of PIPE_STAGES stages.
// Latency: PIPE_STAGES cycles from input transfer to out_valid when not stalled; 1 beat/cycle sustained.
// Backpressure: full valid/ready; in_ready is combinational from out_ready, so the chain never bubbles.
module sbox_lane_pipe #(
    parameter int NUM_LANES   = 4,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_LANES-1:0] in_data,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_LANES-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_inv,
    output logic                   busy
);

    localparam int W = 8*NUM_LANES;

    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    logic [W-1:0]     lk_src;
    logic [W-1:0]     lk_res;
    logic             lk_inv;

    logic             s1_vld;
    logic             s1_inv;
    logic             s1_adv;
    logic [W-1:0]     s1_dat;
    logic [W-1:0]     s1_nxt;
    logic [TAG_W-1:0] s1_tag;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lk_res[8*i +: 8] = lk_inv ? INV_SBOX[lk_src[8*i +: 8]] : FWD_SBOX[lk_src[8*i +: 8]];
    end

    if (PIPE_STAGES == 1) begin : g_one
        // Lookup sits in front of the only register.
        assign lk_src    = in_data;
        assign lk_inv    = in_inv;
        assign s1_nxt    = lk_res;
        assign s1_adv    = !s1_vld || out_ready;
        assign out_valid = s1_vld;
        assign out_data  = s1_dat;
        assign out_tag   = s1_tag;
        assign out_inv   = s1_inv;
        assign busy      = s1_vld;
    end else begin : g_two
        logic             s2_vld;
        logic             s2_inv;
        logic             s2_adv;
        logic [W-1:0]     s2_dat;
        logic [TAG_W-1:0] s2_tag;

        // Stage 1 holds raw bytes; the lookup is retimed between the two registers.
        assign lk_src    = s1_dat;
        assign lk_inv    = s1_inv;
        assign s1_nxt    = in_data;
        assign s2_adv    = !s2_vld || out_ready;
        assign s1_adv    = !s1_vld || s2_adv;
        assign out_valid = s2_vld;
        assign out_data  = s2_dat;
        assign out_tag   = s2_tag;
        assign out_inv   = s2_inv;
        assign busy      = s1_vld || s2_vld;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
                s2_tag <= '0;
                s2_inv <= 1'b0;
            end else if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= lk_res;
                    s2_tag <= s1_tag;
                    s2_inv <= s1_inv;
                end
            end
        end
    end

    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
            s1_tag <= '0;
            s1_inv <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat <= s1_nxt;
                s1_tag <= in_tag;
                s1_inv <= in_inv;
            end
        end
    end

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Bench for sbox_lane_pipe: 4-lane/1-stage and 16-lane/2-stage instances against a GF(2^8) reference.
module tb_sbox_lane_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    // 4 lanes, 1 stage
    logic        a_rst, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_in_tag, a_out_tag;
    // 16 lanes, 2 stages
    logic         b_rst, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
    logic [127:0] b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;

    sbox_lane_pipe #(.NUM_LANES(4), .PIPE_STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
        .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_tag(a_out_tag), .out_inv(a_out_inv), .busy(a_busy));

    sbox_lane_pipe #(.NUM_LANES(16), .PIPE_STAGES(2), .TAG_W(4)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
        .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag), .out_inv(b_out_inv), .busy(b_busy));

    typedef struct {
        logic        inv;
        logic [31:0] data;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
        logic         inv;
    } beat_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse in GF(2^8) followed by the AES affine map.
    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] r = 8'h00;
        if (x != 8'h00) begin
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] m_sub(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r = '0;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = inv ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [6];
        beat_t        q [$];
        beat_t        hd;
        logic [127:0] d1, d2, d3, dd, pd, rr;
        logic         pinv, hold, prev_stall;
        logic [127:0] prev_dat;
        logic         v;

        vecs = '{
            '{1'b0, 32'h00010253, 4'h5, 32'h637c77ed},
            '{1'b1, 32'h637c77ed, 4'h6, 32'h00010253},
            '{1'b0, 32'hffffffff, 4'h7, 32'h16161616},
            '{1'b1, 32'h00000000, 4'h8, 32'h52525252},
            '{1'b0, 32'h11223344, 4'h9, 32'h8293c31b},
            '{1'b1, 32'h167c630c, 4'ha, 32'hff010081}
        };

        for (int x = 0; x < 256; x++) begin
            m_fwd[x]        = sbox_math(8'(x));
            m_inv[m_fwd[x]] = 8'(x);
        end

        a_rst = 1; a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_in_tag = '0; a_out_ready = 0;
        b_rst = 1; b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_in_tag = '0; b_out_ready = 0;
        tick(); tick();
        a_rst = 0; b_rst = 0;
        #1;
        check("a_rst_out_valid", 128'(a_out_valid), 128'(0));
        check("a_rst_busy",      128'(a_busy),      128'(0));
        check("a_rst_out_data",  128'(a_out_data),  128'(0));
        check("a_rst_out_tag",   128'(a_out_tag),   128'(0));
        check("a_rst_out_inv",   128'(a_out_inv),   128'(0));
        check("a_rst_in_ready",  128'(a_in_ready),  128'(1));
        check("b_rst_out_valid", 128'(b_out_valid), 128'(0));
        check("b_rst_busy",      128'(b_busy),      128'(0));
        check("b_rst_out_data",  b_out_data,        128'(0));
        check("b_rst_in_ready",  128'(b_in_ready),  128'(1));

        // Known-answer vectors, back to back, latency 1.
        a_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1; a_in_inv = vecs[i].inv; a_in_data = vecs[i].data; a_in_tag = vecs[i].tag;
            #1;
            check("vec_in_ready", 128'(a_in_ready), 128'(1));
            tick();
            check("vec_out_valid", 128'(a_out_valid), 128'(1));
            check("vec_out_data",  128'(a_out_data),  128'(vecs[i].exp));
            check("vec_out_tag",   128'(a_out_tag),   128'(vecs[i].tag));
            check("vec_out_inv",   128'(a_out_inv),   128'(vecs[i].inv));
        end
        a_in_valid = 0;
        tick();
        check("vec_idle_out_valid", 128'(a_out_valid), 128'(0));

        // Random streaming on the 1-stage unit: every accepted beat appears exactly one cycle later.
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(3) != 0);
            a_in_valid = v; a_in_data = $urandom; a_in_inv = 1'($urandom); a_in_tag = 4'($urandom);
            dd = m_sub(128'(a_in_data), a_in_inv, 4);
            pinv = a_in_inv;
            hd.tag = a_in_tag;
            tick();
            check("a_rnd_out_valid", 128'(a_out_valid), 128'(v));
            if (v) begin
                check("a_rnd_out_data", 128'(a_out_data), dd);
                check("a_rnd_out_tag",  128'(a_out_tag),  128'(hd.tag));
                check("a_rnd_out_inv",  128'(a_out_inv),  128'(pinv));
            end
        end
        a_in_valid = 0;

        // Sweep every byte through both tables on 16 lanes, back to back, alternating mode.
        b_out_ready = 1;
        pd = '0; pinv = 0;
        for (int b = 0; b < 256; b++) begin
            for (int i = 0; i < 16; i++) dd[8*i +: 8] = 8'(b + i);
            b_in_valid = 1; b_in_data = dd; b_in_inv = 1'(b); b_in_tag = 4'(b);
            check("sweep_in_ready", 128'(b_in_ready), 128'(1));
            tick();
            if (b == 0) begin
                check("sweep_latency2", 128'(b_out_valid), 128'(0));
            end else begin
                check("sweep_out_valid", 128'(b_out_valid), 128'(1));
                check("sweep_out_data",  b_out_data,        m_sub(pd, pinv, 16));
                check("sweep_out_inv",   128'(b_out_inv),   128'(pinv));
            end
            pd = dd; pinv = 1'(b);
        end
        b_in_valid = 0;
        tick();
        check("sweep_last_valid", 128'(b_out_valid), 128'(1));
        check("sweep_last_data",  b_out_data,        m_sub(pd, pinv, 16));
        tick();
        check("sweep_drained", 128'(b_out_valid), 128'(0));

        // Round trip: forward result fed back through the inverse must restore every byte.
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) dd[8*i +: 8] = 8'(16*j + i);
            b_in_valid = 1; b_in_data = dd; b_in_inv = 0;
            tick();
            b_in_valid = 0;
            tick();
            check("rt_fwd_valid", 128'(b_out_valid), 128'(1));
            rr = b_out_data;
            b_in_valid = 1; b_in_data = rr; b_in_inv = 1;
            tick();
            b_in_valid = 0;
            tick();
            check("rt_inv_valid", 128'(b_out_valid), 128'(1));
            check("rt_identity",  b_out_data,        dd);
        end
        tick();

        // Backpressure: two beats fill the unit, the third is held off.
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        d3 = {$urandom, $urandom, $urandom, $urandom};
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = d1; b_in_tag = 1; b_in_inv = 0;
        #1;
        check("bp_accept1", 128'(b_in_ready), 128'(1));
        tick();
        b_in_data = d2; b_in_tag = 2; b_in_inv = 1;
        #1;
        check("bp_accept2",    128'(b_in_ready),  128'(1));
        check("bp_not_yet_out", 128'(b_out_valid), 128'(0));
        tick();
        b_in_data = d3; b_in_tag = 3; b_in_inv = 0;
        #1;
        check("bp_full_in_ready", 128'(b_in_ready),  128'(0));
        check("bp_full_busy",     128'(b_busy),      128'(1));
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 128'(b_out_valid), 128'(1));
            check("bp_hold_tag",   128'(b_out_tag),   128'(1));
            check("bp_hold_data",  b_out_data,        m_sub(d1, 0, 16));
            check("bp_hold_rdy",   128'(b_in_ready),  128'(0));
            tick();
        end
        // Full unit, out and in transfer in the same cycle.
        b_out_ready = 1;
        #1;
        check("simul_in_ready", 128'(b_in_ready), 128'(1));
        tick();
        b_in_valid = 0; b_out_ready = 0;
        #1;
        check("simul_busy",     128'(b_busy),      128'(1));
        check("simul_still_full", 128'(b_in_ready), 128'(0));
        check("order_tag2",     128'(b_out_tag),   128'(2));
        check("order_data2",    b_out_data,        m_sub(d2, 1, 16));
        check("order_inv2",     128'(b_out_inv),   128'(1));
        b_out_ready = 1;
        tick();
        check("order_valid3", 128'(b_out_valid), 128'(1));
        check("order_tag3",   128'(b_out_tag),   128'(3));
        check("order_data3",  b_out_data,        m_sub(d3, 0, 16));
        tick();
        check("order_empty",      128'(b_out_valid), 128'(0));
        check("order_empty_busy", 128'(b_busy),      128'(0));

        // Reset with two beats in flight.
        b_out_ready = 0;
        b_in_valid = 1; b_in_data = d1; b_in_tag = 5;
        tick();
        b_in_data = d2; b_in_tag = 6;
        tick();
        b_in_valid = 0;
        check("mid_busy", 128'(b_busy), 128'(1));
        b_rst = 1;
        tick();
        b_rst = 0;
        #1;
        check("mid_rst_out_valid", 128'(b_out_valid), 128'(0));
        check("mid_rst_busy",      128'(b_busy),      128'(0));
        check("mid_rst_in_ready",  128'(b_in_ready),  128'(1));
        b_out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_rst_no_stale", 128'(b_out_valid), 128'(0));
        end

        // Random traffic with random backpressure against a queue model of capacity 2.
        hold = 0; prev_stall = 0; prev_dat = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                b_in_valid = ($urandom_range(9) < 7);
                b_in_data  = {$urandom, $urandom, $urandom, $urandom};
                b_in_tag   = 4'($urandom);
                b_in_inv   = 1'($urandom);
            end
            b_out_ready = ($urandom_range(2) != 0);
            #1;
            check("rnd_in_ready", 128'(b_in_ready), 128'(q.size() < 2 || b_out_ready));
            check("rnd_busy",     128'(b_busy),     128'(q.size() != 0));
            if (prev_stall) begin
                check("rnd_stall_valid", 128'(b_out_valid), 128'(1));
                check("rnd_stall_data",  b_out_data,        prev_dat);
            end
            if (b_out_valid) begin
                check("rnd_nonempty", 128'(q.size() != 0), 128'(1));
                if (b_out_ready && q.size() != 0) begin
                    hd = q.pop_front();
                    check("rnd_data", b_out_data,        hd.data);
                    check("rnd_tag",  128'(b_out_tag),   128'(hd.tag));
                    check("rnd_inv",  128'(b_out_inv),   128'(hd.inv));
                end
            end
            if (b_in_valid && b_in_ready) begin
                hd.data = m_sub(b_in_data, b_in_inv, 16); hd.tag = b_in_tag; hd.inv = b_in_inv;
                q.push_back(hd);
                hold = 0;
            end else begin
                hold = b_in_valid;
            end
            prev_stall = b_out_valid && !b_out_ready;
            prev_dat   = b_out_data;
            tick();
        end
        b_in_valid = 0; b_out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (b_out_valid) begin
                check("drain_nonempty", 128'(q.size() != 0), 128'(1));
                if (q.size() != 0) begin
                    hd = q.pop_front();
                    check("drain_data", b_out_data,      hd.data);
                    check("drain_tag",  128'(b_out_tag), 128'(hd.tag));
                end
            end
            tick();
        end
        check("drain_all_out", 128'(q.size()), 128'(0));
        check("drain_idle",    128'(b_busy),   128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
